// File: rtl/halt_responder_if.sv
// Run-control handshake bundle between the clock/reset controller
// and the CPU-side halt responder.
interface halt_responder_if #(
  parameter int CNT_W = 16
);
  logic             enable;
  logic             hlt_decoded;
  logic             fetch_en;
  logic             decode_en;
  logic             exec_en;
  logic             wb_en;
  logic             halted;
  logic             is_halted;
  logic [CNT_W-1:0] retired;

  modport master (
    output enable,
    output hlt_decoded,
    input  fetch_en,
    input  decode_en,
    input  exec_en,
    input  wb_en,
    input  halted,
    input  is_halted,
    input  retired
  );

  modport slave (
    input  enable,
    input  hlt_decoded,
    output fetch_en,
    output decode_en,
    output exec_en,
    output wb_en,
    output halted,
    output is_halted,
    output retired
  );
endinterface

// File: rtl/halt_responder.sv
// Sequences FETCH/DECODE/EXEC/WB strobes, drains a decoded HLT and
// returns a fixed-width halted pulse to the run controller.
module halt_responder #(
  parameter int HALT_PULSE = 2,
  parameter int CNT_W      = 16
) (
  input logic             clk1,
  input logic             reset,
  halt_responder_if.slave bus
);

  localparam int PW =
    (HALT_PULSE > 1) ? $clog2(HALT_PULSE) : 1;

  typedef enum logic [1:0] {
    ST_RUN, ST_DRAIN, ST_PULSE, ST_HALTED
  } state_t;

  typedef enum logic [1:0] {
    PH_F, PH_D, PH_E, PH_W
  } phase_t;

  state_t           r_state;
  state_t           w_state_nx;
  phase_t           r_phase;
  phase_t           w_phase_nx;
  logic [PW-1:0]    r_pcnt;
  logic [PW-1:0]    w_pcnt_nx;
  logic [3:0]       r_strb;
  logic [3:0]       w_strb_nx;
  logic             w_step;
  logic             r_en_q;
  logic             w_halted;
  logic             w_is_halted;
  logic [CNT_W-1:0] r_retired;

  always_ff @(posedge clk1) begin
    if (!reset) begin
      r_state <= ST_RUN;
      r_phase <= PH_F;
      r_pcnt  <= '0;
      r_strb  <= '0;
      r_en_q  <= 1'b1;
    end else begin
      r_state <= w_state_nx;
      r_phase <= w_phase_nx;
      r_pcnt  <= w_pcnt_nx;
      r_strb  <= w_strb_nx;
      r_en_q  <= bus.enable;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_phase_nx = r_phase;
    w_pcnt_nx  = r_pcnt;
    w_step     = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        if (bus.enable) begin
          w_step     = 1'b1;
          w_phase_nx = phase_t'(r_phase + 2'd1);
          if (r_phase == PH_D && bus.hlt_decoded)
            w_state_nx = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Phase back at FETCH means the HLT's WB strobe has gone out
        if (r_phase == PH_F) begin
          w_state_nx = ST_PULSE;
          w_pcnt_nx  = '0;
        end else if (bus.enable) begin
          w_step     = 1'b1;
          w_phase_nx = phase_t'(r_phase + 2'd1);
        end
      end
      ST_PULSE: begin
        if (r_pcnt == PW'(HALT_PULSE - 1)) begin
          w_state_nx = ST_HALTED;
          w_pcnt_nx  = '0;
        end else begin
          w_pcnt_nx = r_pcnt + 1'b1;
        end
      end
      ST_HALTED: begin
        w_phase_nx = PH_F;
        if (bus.enable && !r_en_q)
          w_state_nx = ST_RUN;
      end
    endcase
  end

  always_comb begin
    w_strb_nx   = '0;
    if (w_step)
      w_strb_nx = 4'b0001 << r_phase;
    w_halted    = (r_state == ST_PULSE);
    w_is_halted = (r_state == ST_PULSE) ||
                  (r_state == ST_HALTED);
  end

  always_ff @(posedge clk1) begin
    if (!reset)
      r_retired <= '0;
    else if (w_strb_nx[3] && r_retired != '1)
      r_retired <= r_retired + 1'b1;
  end

  assign bus.fetch_en  = r_strb[0];
  assign bus.decode_en = r_strb[1];
  assign bus.exec_en   = r_strb[2];
  assign bus.wb_en     = r_strb[3];
  assign bus.halted    = w_halted;
  assign bus.is_halted = w_is_halted;
  assign bus.retired   = r_retired;

endmodule
